// File: rtl/hms_clock_sequencer.sv
// H:M:S control: tick divider, button debounce, CLOCK/SETUP/ALARM FSM, increment enables, blink masks.
// Outputs registered, 1 clk after the causing tick/press; no backpressure (enables are fire-and-forget pulses).
module hms_clock_sequencer #(
    parameter int SEC_DIV   = 50000000,
    parameter int DEB_DIV   = 500000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sec_at_max,
    input  logic       i_min_at_max,
    output logic [2:0] o_time_inc,
    output logic [2:0] o_alm_inc,
    output logic [1:0] o_mode,
    output logic [1:0] o_position,
    output logic [5:0] o_digit_blank
);

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SETUP = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    localparam int SEC_W   = (SEC_DIV > 1)   ? $clog2(SEC_DIV)   : 1;
    localparam int DEB_W   = (DEB_DIV > 1)   ? $clog2(DEB_DIV)   : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SEC_W-1:0]   sec_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               tick;
    logic               deb_strobe;
    logic               strobe_d;
    logic               phase;
    logic               phase_nxt;
    logic [2:0]         sync0;
    logic [2:0]         sync1;
    logic [2:0]         hist_prev;
    logic [2:0]         hist_cur;
    logic [2:0]         press;
    logic [1:0]         mode;
    logic [1:0]         mode_nxt;
    logic [1:0]         position;
    logic [1:0]         position_nxt;
    logic               mode_change;
    logic [2:0]         pos_onehot;
    logic [2:0]         time_inc_nxt;
    logic [2:0]         alm_inc_nxt;
    logic [5:0]         blank_nxt;

    assign tick       = (sec_cnt == SEC_LAST);
    assign deb_strobe = (deb_cnt == DEB_LAST);

    // Restart the second on leaving SETUP so the first post-edit second is full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= '0;
        end else if ((mode == MODE_SETUP) && mode_change) begin
            sec_cnt <= '0;
        end else if (tick) begin
            sec_cnt <= '0;
        end else begin
            sec_cnt <= sec_cnt + SEC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt   <= '0;
            strobe_d  <= 1'b0;
            sync0     <= 3'b111;
            sync1     <= 3'b111;
            hist_prev <= 3'b111;
            hist_cur  <= 3'b111;
        end else begin
            deb_cnt  <= deb_strobe ? '0 : deb_cnt + DEB_W'(1);
            strobe_d <= deb_strobe;
            sync0    <= {i_sw2, i_sw1, i_sw0};
            sync1    <= sync0;
            if (deb_strobe) begin
                hist_prev <= hist_cur;
                hist_cur  <= sync1;
            end
        end
    end

    // Falling edge of the sampled level, valid only in the cycle right after a sample.
    assign press = {3{strobe_d}} & hist_prev & ~hist_cur;

    always_comb begin
        mode_nxt = mode;
        case (mode)
            MODE_CLOCK: if (press[0]) mode_nxt = MODE_SETUP;
            MODE_SETUP: if (press[0]) mode_nxt = MODE_ALARM;
            MODE_ALARM: if (press[0]) mode_nxt = MODE_CLOCK;
            default:    mode_nxt = MODE_CLOCK;
        endcase
    end

    assign mode_change = (mode_nxt != mode);

    always_comb begin
        pos_onehot = 3'b000;
        case (position)
            POS_SEC:  pos_onehot = 3'b001;
            POS_MIN:  pos_onehot = 3'b010;
            POS_HOUR: pos_onehot = 3'b100;
            default:  pos_onehot = 3'b000;
        endcase
    end

    always_comb begin
        position_nxt = position;
        if (mode_change) begin
            position_nxt = POS_SEC;
        end else if (press[1] && (mode != MODE_CLOCK)) begin
            position_nxt = (position >= POS_HOUR) ? POS_SEC : position + 2'd1;
        end
    end

    always_comb begin
        time_inc_nxt = 3'b000;
        alm_inc_nxt  = 3'b000;
        case (mode)
            MODE_CLOCK, MODE_ALARM: begin
                time_inc_nxt = {tick & i_sec_at_max & i_min_at_max, tick & i_sec_at_max, tick};
            end
            MODE_SETUP: begin
                if (press[2] && !mode_change) time_inc_nxt = pos_onehot;
            end
            default: time_inc_nxt = 3'b000;
        endcase
        if ((mode == MODE_ALARM) && press[2] && !mode_change) alm_inc_nxt = pos_onehot;
    end

    assign phase_nxt = (blink_cnt == BLINK_LAST) ? ~phase : phase;

    // Mask is built from next-state values so it moves on the same edge as mode/position.
    always_comb begin
        blank_nxt = 6'b000000;
        if (phase_nxt && ((mode_nxt == MODE_SETUP) || (mode_nxt == MODE_ALARM))) begin
            case (position_nxt)
                POS_SEC:  blank_nxt = 6'b000011;
                POS_MIN:  blank_nxt = 6'b001100;
                POS_HOUR: blank_nxt = 6'b110000;
                default:  blank_nxt = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt     <= '0;
            phase         <= 1'b0;
            mode          <= MODE_CLOCK;
            position      <= POS_SEC;
            o_time_inc    <= 3'b000;
            o_alm_inc     <= 3'b000;
            o_digit_blank <= 6'b000000;
        end else begin
            blink_cnt     <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_W'(1);
            phase         <= phase_nxt;
            mode          <= mode_nxt;
            position      <= position_nxt;
            o_time_inc    <= time_inc_nxt;
            o_alm_inc     <= alm_inc_nxt;
            o_digit_blank <= blank_nxt;
        end
    end

    assign o_mode     = mode;
    assign o_position = position;

endmodule

// File: tb/tb_hms_clock_sequencer.sv
// Bench for hms_clock_sequencer: edge-indexed reference model compared every cycle, plus directed literal checks.
module tb_hms_clock_sequencer;

    localparam int S = 10;
    localparam int D = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sw0 = 1'b1;
    logic       sw1 = 1'b1;
    logic       sw2 = 1'b1;
    logic       sec_max = 1'b0;
    logic       min_max = 1'b0;
    logic [2:0] time_inc;
    logic [2:0] alm_inc;
    logic [1:0] mode;
    logic [1:0] position;
    logic [5:0] blank;

    int vectors = 0;
    int miscompares = 0;

    int cnt_t001, cnt_t010, cnt_t111, cnt_t_other;
    int cnt_a100, cnt_a_other;
    int cnt_bh, cnt_b0, cnt_b_other;

    hms_clock_sequencer #(
        .SEC_DIV   (S),
        .DEB_DIV   (D),
        .BLINK_DIV (B)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sw0         (sw0),
        .i_sw1         (sw1),
        .i_sw2         (sw2),
        .i_sec_at_max  (sec_max),
        .i_min_at_max  (min_max),
        .o_time_inc    (time_inc),
        .o_alm_inc     (alm_inc),
        .o_mode        (mode),
        .o_position    (position),
        .o_digit_blank (blank)
    );

    initial forever #5 clk = ~clk;

    // Reference model: k counts clock edges since reset release; dividers are pure arithmetic on k.
    int         k;
    int         base;
    logic [1:0] m_mode, m_pos;
    logic [2:0] m_time, m_alm;
    logic [5:0] m_blank;
    logic       tick_p;
    logic [2:0] press_p, prev_s;
    logic [2:0] raw_log[$];

    function automatic logic [2:0] onehot(input logic [1:0] p);
        logic [2:0] one;
        one = 3'b001;
        return one << p;
    endfunction

    function automatic logic [5:0] digits(input logic [1:0] p);
        logic [5:0] pair;
        pair = 6'b000011;
        return pair << (2 * p);
    endfunction

    task automatic model_reset();
        k = 0; base = 0;
        m_mode = 2'd0; m_pos = 2'd0;
        m_time = 3'b000; m_alm = 3'b000; m_blank = 6'b000000;
        tick_p = 1'b0; press_p = 3'b000; prev_s = 3'b111;
        raw_log.delete();
    endtask

    task automatic model_step();
        logic [1:0] nm;
        logic [2:0] s;
        k = k + 1;
        raw_log.push_back({sw2, sw1, sw0});
        nm = press_p[0] ? 2'((int'(m_mode) + 1) % 3) : m_mode;
        if (m_mode == 2'd1)
            m_time = (press_p[2] && !press_p[0]) ? onehot(m_pos) : 3'b000;
        else
            m_time = {tick_p & sec_max & min_max, tick_p & sec_max, tick_p};
        m_alm = (m_mode == 2'd2 && press_p[2] && !press_p[0]) ? onehot(m_pos) : 3'b000;
        if (nm != m_mode) begin
            if (m_mode == 2'd1) base = k;
            m_pos = 2'd0;
        end else if (press_p[1] && m_mode != 2'd0) begin
            m_pos = 2'((int'(m_pos) + 1) % 3);
        end
        m_mode = nm;
        m_blank = (((k / B) % 2) == 1 && m_mode != 2'd0) ? digits(m_pos) : 6'b000000;
        tick_p = ((k - base) % S) == S - 1;
        if (k % D == 0) begin
            s = raw_log[k - 3];
            press_p = prev_s & ~s;
            prev_s = s;
        end else begin
            press_p = 3'b000;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model, plus pattern counters for the directed checks.
    initial forever begin
        @(negedge clk);
        vectors++;
        if ({time_inc, alm_inc, mode, position, blank} !== {m_time, m_alm, m_mode, m_pos, m_blank}) begin
            miscompares++;
            $display("FAIL cycle_model k=%0d actual time=%b alm=%b mode=%0d pos=%0d blank=%b required time=%b alm=%b mode=%0d pos=%0d blank=%b",
                     k, time_inc, alm_inc, mode, position, blank, m_time, m_alm, m_mode, m_pos, m_blank);
        end
        case (time_inc)
            3'b000: ;
            3'b001: cnt_t001++;
            3'b010: cnt_t010++;
            3'b111: cnt_t111++;
            default: cnt_t_other++;
        endcase
        case (alm_inc)
            3'b000: ;
            3'b100: cnt_a100++;
            default: cnt_a_other++;
        endcase
        case (blank)
            6'b000000: cnt_b0++;
            6'b110000: cnt_bh++;
            default: cnt_b_other++;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        cnt_t001 = 0; cnt_t010 = 0; cnt_t111 = 0; cnt_t_other = 0;
        cnt_a100 = 0; cnt_a_other = 0;
        cnt_bh = 0; cnt_b0 = 0; cnt_b_other = 0;
    endtask

    task automatic push(input int btn);
        case (btn)
            0: sw0 = 1'b0;
            1: sw1 = 1'b0;
            default: sw2 = 1'b0;
        endcase
        cyc(12);
        sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1;
        cyc(12);
    endtask

    initial begin
        int n;
        bit found;
        clear_counts();
        #2 rst_n = 1'b0;
        cyc(2);
        chk("reset_outputs", 32'({time_inc, alm_inc, mode, position, blank}), 32'd0);
        rst_n = 1'b1;

        // CLOCK: one tick every S clocks, full carry when both max flags are set
        clear_counts();
        cyc(40);
        chk("tick_count_40clk", cnt_t001, 4);
        chk("tick_no_other", cnt_t010 + cnt_t111 + cnt_t_other, 0);
        sec_max = 1'b1; min_max = 1'b1;
        clear_counts();
        cyc(20);
        chk("carry_pulse_111", cnt_t111, 2);
        sec_max = 1'b0; min_max = 1'b0;

        // held mode button steps exactly once; then SETUP -> ALARM -> CLOCK
        sw0 = 1'b0;
        cyc(40);
        chk("held_sw0_mode", mode, 1);
        sw0 = 1'b1;
        cyc(12);
        chk("held_sw0_no_repeat", mode, 1);
        push(0);
        chk("mode_alarm", mode, 2);
        push(0);
        chk("mode_clock", mode, 0);

        // SETUP: position step and three manual minute increments, no ticks
        push(0);
        chk("enter_setup", mode, 1);
        clear_counts();
        push(1);
        chk("setup_pos_min", position, 1);
        push(2); push(2); push(2);
        chk("setup_min_incs", cnt_t010, 3);
        chk("setup_no_ticks", cnt_t001 + cnt_t111 + cnt_t_other, 0);

        // sw0 and sw2 together in SETUP: mode wins, no increment
        clear_counts();
        sw0 = 1'b0; sw2 = 1'b0;
        cyc(12);
        sw0 = 1'b1; sw2 = 1'b1;
        cyc(12);
        chk("simul_mode", mode, 2);
        chk("simul_pos_sec", position, 0);
        chk("simul_no_inc", cnt_t010 + cnt_a100 + cnt_a_other, 0);

        // ALARM at HOUR: blink pattern and alarm increment alongside ticks
        push(1); push(1);
        chk("alarm_pos_hour", position, 2);
        clear_counts();
        cyc(32);
        chk("blink_hour_on", cnt_bh, 16);
        chk("blink_hour_off", cnt_b0, 16);
        chk("blink_other", cnt_b_other, 0);
        clear_counts();
        push(2);
        chk("alarm_hour_inc", cnt_a100, 1);
        chk("alarm_other_inc", cnt_a_other, 0);
        chk("alarm_ticks_continue", 32'(cnt_t001 >= 2), 32'd1);

        // reset mid-blink at MIN, then first tick exactly S clocks after release
        push(1); push(1);
        chk("alarm_pos_min", position, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (blank == 6'b001100) found = 1'b1;
        end
        chk("blink_min_seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({time_inc, alm_inc, mode, position, blank}), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cyc(1);
            n++;
            if (time_inc != 3'b000) found = 1'b1;
        end
        chk("first_tick_after_reset", n, S);
        chk("first_tick_value", 32'(time_inc), 32'd1);
        chk("mode_after_reset", mode, 0);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
